// File: rtl/wb_queue.sv
`default_nettype none
// ==========================================================================
// wb_queue - writeback line FIFO, drains each 256-bit line as two beats. r1.0
// ==========================================================================
module wb_queue #(
    parameter int DEPTH   = 4,
    parameter int NLINE_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_wvalid,
    output logic                     in_wready,
    input  logic [NLINE_W-1:0]       in_wid,
    input  logic [255:0]             in_wdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [NLINE_W-1:0]       mem_id,
    output logic                     mem_beat,
    output logic                     mem_last,
    output logic [127:0]             mem_data,
    input  logic [NLINE_W-1:0]       probe_id,
    output logic                     probe_hit,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [PW-1:0]        count_q, count_d;
    logic [DEPTH-1:0]     occ_q, occ_d;
    logic [NLINE_W-1:0]   id_mem   [DEPTH];
    logic [255:0]         data_mem [DEPTH];
    logic                 enq;
    logic                 deq;
    logic [AW-1:0]        head_idx;
    logic [AW-1:0]        tail_idx;

    assign head_idx  = head_q[AW-1:0];
    assign tail_idx  = tail_q[AW-1:0];
    assign in_wready = (count_q != PW'(DEPTH));
    assign enq       = in_wvalid && in_wready;
    assign deq       = (state_q == BEAT1) && mem_ready;

    always_comb begin
        head_d  = head_q + {{AW{1'b0}}, deq};
        tail_d  = tail_q + {{AW{1'b0}}, enq};
        occ_d   = occ_q;
        count_d = count_q;
        if (deq) occ_d[head_idx] = 1'b0;
        if (enq) occ_d[tail_idx] = 1'b1;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    // Leaving IDLE on the enqueue edge itself gives mem_valid in the first cycle count >= 1.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (count_q != '0 || enq) state_d = BEAT0;
            BEAT0:   if (mem_ready) state_d = BEAT1;
            BEAT1:   if (mem_ready) state_d = (count_d != '0) ? BEAT0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            id_mem[tail_idx]   <= in_wid;
            data_mem[tail_idx] <= in_wdata;
        end
    end

    assign mem_valid = (state_q != IDLE);
    assign mem_beat  = (state_q == BEAT1);
    assign mem_last  = (state_q == BEAT1);
    assign mem_id    = id_mem[head_idx];
    assign mem_data  = mem_beat ? data_mem[head_idx][255:128] : data_mem[head_idx][127:0];
    assign count     = count_q;

    // Occupancy bits are registered, so same-cycle enqueue/dequeue do not affect the probe.
    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ_q[i] && (id_mem[i] == probe_id)) probe_hit = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ==========================================================================
// tb_wb_queue - randomized bench for wb_queue against a line-queue model. r1.0
// ==========================================================================
module tb_wb_queue;

    localparam int DEPTH   = 4;
    localparam int NLINE_W = 12;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_wvalid = 1'b0;
    logic               in_wready;
    logic [NLINE_W-1:0] in_wid = '0;
    logic [255:0]       in_wdata = '0;
    logic               mem_valid;
    logic               mem_ready = 1'b0;
    logic [NLINE_W-1:0] mem_id;
    logic               mem_beat;
    logic               mem_last;
    logic [127:0]       mem_data;
    logic [NLINE_W-1:0] probe_id = '0;
    logic               probe_hit;
    logic [2:0]         count;

    int n_total = 0;
    int n_pass  = 0;

    wb_queue #(.DEPTH(DEPTH), .NLINE_W(NLINE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_wvalid (in_wvalid),
        .in_wready (in_wready),
        .in_wid    (in_wid),
        .in_wdata  (in_wdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_id    (mem_id),
        .mem_beat  (mem_beat),
        .mem_last  (mem_last),
        .mem_data  (mem_data),
        .probe_id  (probe_id),
        .probe_hit (probe_hit),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Model: a queue of pending lines plus a flag saying the head's low half has gone out.
    typedef struct {
        logic [NLINE_W-1:0] id;
        logic [255:0]       data;
    } line_t;

    line_t m_q[$];
    bit    m_half = 1'b0;
    bit    m_enq;
    bit    m_beat_ok;
    bit    chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_half = 1'b0;
        end else begin
            m_enq     = in_wvalid && (m_q.size() < DEPTH);
            m_beat_ok = mem_ready && (m_q.size() > 0);
            if (m_beat_ok) begin
                if (m_half) begin
                    void'(m_q.pop_front());
                    m_half = 1'b0;
                end else begin
                    m_half = 1'b1;
                end
            end
            if (m_enq) m_q.push_back('{id: in_wid, data: in_wdata});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_hit;
            logic exp_v;
            exp_v   = (m_q.size() != 0);
            exp_hit = 1'b0;
            foreach (m_q[i]) if (m_q[i].id == probe_id) exp_hit = 1'b1;
            check("mem_valid", {255'd0, mem_valid}, {255'd0, exp_v});
            check("count", {253'd0, count}, 256'(m_q.size()));
            check("in_wready", {255'd0, in_wready}, {255'd0, m_q.size() < DEPTH});
            check("probe_hit", {255'd0, probe_hit}, {255'd0, exp_hit});
            check("mem_beat", {255'd0, mem_beat}, {255'd0, exp_v && m_half});
            check("mem_last", {255'd0, mem_last}, {255'd0, exp_v && m_half});
            if (exp_v) begin
                check("mem_id", {244'd0, mem_id}, {244'd0, m_q[0].id});
                check("mem_data", {128'd0, mem_data},
                      {128'd0, m_half ? m_q[0].data[255:128] : m_q[0].data[127:0]});
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] ab;
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Single line with memory always ready
        ab        = {{8{16'hBBBB}}, {8{16'hAAAA}}, {8{16'hAAAA}}};
        ab        = {128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB,
                     128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA};
        in_wvalid = 1'b1;
        in_wid    = 12'h0A5;
        in_wdata  = ab;
        mem_ready = 1'b1;
        next_cycle();
        in_wvalid = 1'b0;
        @(negedge clk);
        check("lit_beat0_valid", {255'd0, mem_valid}, 256'd1);
        check("lit_beat0_last", {255'd0, mem_last}, 256'd0);
        check("lit_beat0_data", {128'd0, mem_data}, {128'd0, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA});
        check("lit_beat0_id", {244'd0, mem_id}, 256'h0A5);
        @(negedge clk);
        check("lit_beat1_last", {255'd0, mem_last}, 256'd1);
        check("lit_beat1_data", {128'd0, mem_data}, {128'd0, 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB});
        @(negedge clk);
        check("lit_idle_valid", {255'd0, mem_valid}, 256'd0);
        check("lit_idle_count", {253'd0, count}, 256'd0);

        // Fill to full with memory stalled, offer a fifth line, then drain
        next_cycle();
        mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_wvalid = 1'b1;
            in_wid    = 12'(k + 1);
            in_wdata  = rand256();
            next_cycle();
        end
        in_wid   = 12'h005;
        in_wdata = rand256();
        @(negedge clk);
        check("lit_full_count", {253'd0, count}, 256'd4);
        check("lit_full_wready", {255'd0, in_wready}, 256'd0);
        next_cycle();
        in_wvalid = 1'b0;
        mem_ready = 1'b1;
        repeat (10) next_cycle();

        // Full queue with offers held: count oscillates between 3 and 4
        mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_wvalid = 1'b1;
            in_wid    = 12'h100 | 12'(k);
            in_wdata  = rand256();
            next_cycle();
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_wid   = 12'h180 | 12'(k);
            in_wdata = rand256();
            next_cycle();
        end
        in_wvalid = 1'b0;
        repeat (10) next_cycle();

        // Probe across a line's lifetime
        mem_ready = 1'b0;
        in_wvalid = 1'b1;
        in_wid    = 12'h123;
        in_wdata  = rand256();
        probe_id  = 12'h123;
        next_cycle();
        in_wvalid = 1'b0;
        @(negedge clk);
        check("lit_probe_hit", {255'd0, probe_hit}, 256'd1);
        probe_id = 12'h124;
        #1;
        check("lit_probe_miss", {255'd0, probe_hit}, 256'd0);
        probe_id = 12'h123;
        next_cycle();
        mem_ready = 1'b1;
        repeat (4) next_cycle();

        // Reset pulse while sitting in the second beat
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_wvalid = 1'b1;
            in_wid    = 12'h201 + 12'(k);
            in_wdata  = rand256();
            next_cycle();
        end
        in_wvalid = 1'b0;
        probe_id  = 12'h201;
        mem_ready = 1'b1;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("lit_rst_valid", {255'd0, mem_valid}, 256'd0);
        check("lit_rst_beat", {255'd0, mem_beat}, 256'd0);
        check("lit_rst_last", {255'd0, mem_last}, 256'd0);
        check("lit_rst_count", {253'd0, count}, 256'd0);
        check("lit_rst_wready", {255'd0, in_wready}, 256'd1);
        check("lit_rst_probe", {255'd0, probe_hit}, 256'd0);
        repeat (2) next_cycle();
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        repeat (4) next_cycle();
        @(negedge clk);
        check("lit_post_rst_valid", {255'd0, mem_valid}, 256'd0);

        // Randomized traffic with a narrow id range for duplicates and probe hits
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            in_wvalid = ($urandom_range(0, 99) < 60);
            mem_ready = ($urandom_range(0, 99) < 65);
            in_wid    = 12'h300 | 12'($urandom_range(0, 7));
            in_wdata  = rand256();
            probe_id  = 12'h300 | 12'($urandom_range(0, 7));
        end
        in_wvalid = 1'b0;
        mem_ready = 1'b1;
        repeat (12) next_cycle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
